// File: rtl/delayed_write_engine.sv
// Cancellable timed-write engine: holds one pending write, commits it after a cycle delay unless aborted.
// Optional feature: define DWE_RETRIGGER_EN to let start_i in WAIT replace the pending write.
module delayed_write_engine #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  delay_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              abort_i,
  output logic              busy_o,
  output logic [DATA_W-1:0] value_o,
  output logic              done_o,
  output logic              aborted_o,
  output logic [7:0]        abort_cnt_o
);

  typedef enum logic {
    IDLE,
    WAIT
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] pend_q, pend_d;
  logic [DATA_W-1:0] value_q, value_d;
  logic              done_q, done_d;
  logic              aborted_q, aborted_d;
  logic [7:0]        abort_cnt_q, abort_cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pend_q      <= '0;
      value_q     <= '0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      abort_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      value_q     <= value_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
      abort_cnt_q <= abort_cnt_d;
    end
  end

  // Within WAIT, abort outranks both retrigger and expiry, so a cancelled write never commits.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    value_d     = value_q;
    done_d      = 1'b0;
    aborted_d   = 1'b0;
    abort_cnt_d = abort_cnt_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          cnt_d   = delay_i;
          pend_d  = data_i;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (abort_i) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
          if (abort_cnt_q != '1) begin
            abort_cnt_d = abort_cnt_q + 8'd1;
          end
`ifdef DWE_RETRIGGER_EN
        end else if (start_i) begin
          cnt_d  = delay_i;
          pend_d = data_i;
`endif
        end else if (cnt_q == '0) begin
          value_d = pend_q;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o      = (state_q == WAIT);
  assign value_o     = value_q;
  assign done_o      = done_q;
  assign aborted_o   = aborted_q;
  assign abort_cnt_o = abort_cnt_q;

endmodule

// File: doc/delayed_write_engine.md
# delayed_write_engine

Cancellable timed-write engine: accepts a write of a data word together with a cycle delay, holds it pending, and commits it to a registered output once the delay expires. An abort input cancels any pending write, and a cancelled write never reaches the output. This is the executing side of the disable/abort protocol: a requester issues aborts, and this block owns the pending operation that those aborts kill. It sits between a control sequencer that issues timed updates and the register that consumes them.

## Interface
- DATA_W, 4, width of the data word and of value_o
- CNT_W, 8, width of the delay field
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start_i  in  1  request a timed write; sampled each rising edge
- delay_i  in  CNT_W  delay in cycles, sampled with start_i
- data_i  in  DATA_W  word to commit, sampled with start_i
- abort_i  in  1  cancel the pending write (level, sampled each edge)
- busy_o  out  1  high while a write is pending (state WAIT)
- value_o  out  DATA_W  committed value register
- done_o  out  1  one-cycle pulse on the cycle value_o takes a new value
- aborted_o  out  1  one-cycle pulse when a pending write is cancelled
- abort_cnt_o  out  8  saturating count of cancelled writes

## Operation
- States: IDLE, WAIT. Registers: cnt (CNT_W), pend (DATA_W).
- IDLE: if start_i is high, load cnt<=delay_i and pend<=data_i, then go to WAIT. abort_i is ignored in IDLE: no pulse, and no change to the counter.
- WAIT, evaluated in priority order on each edge:
  1. abort_i: go to IDLE, pulse aborted_o, increment abort_cnt_o (saturating at 255). value_o is unchanged.
  2. cnt==0: value_o<=pend, pulse done_o, go to IDLE.
  3. Otherwise cnt<=cnt-1.
- Abort and expiry in the same cycle: abort wins, and the write is lost.
- start_i in WAIT: behaviour is set by the Configuration macro.
- Start and abort in the same cycle while in IDLE: the start is accepted.
- Start and abort in the same cycle while in WAIT: the abort wins and the start is dropped in both configurations.
- busy_o = (state==WAIT), registered.
- cnt never wraps; it is only decremented when nonzero.
- Reset at any time: all state clears, the pending write is discarded, and no pulses are generated.

## Timing
- Reset values: value_o=0, busy_o=0, done_o=0, aborted_o=0, abort_cnt_o=0, state IDLE.
- Accepted at edge k with delay_i=N: value_o and done_o update at edge k+1+N. busy_o is high from k through k+N, and low after edge k+1+N.
- delay_i=0 gives a commit 1 cycle after accept. Maximum latency is 2^CNT_W cycles.
- A new start can be accepted on the edge after done_o or aborted_o, because the block is back in IDLE then. There is no dead cycle beyond that.
- done_o and aborted_o are mutually exclusive and never high for two consecutive cycles from the same write.

## Configuration
- DWE_RETRIGGER_EN defined: start_i in WAIT (without abort) reloads cnt<=delay_i and pend<=data_i. The old pending write is silently replaced: no aborted_o pulse and no counter increment. Latency is measured from the retrigger edge.
- Not defined: start_i in WAIT is ignored, and the pending write completes with its original data and delay.

## Test plan
- After reset: value_o=0. Start data=1 delay=1, no abort -> busy_o high for 2 cycles, then value_o=1 with a single done_o pulse 2 cycles after the accept edge.
- Start data=1 delay=1, abort_i pulsed on the next edge -> aborted_o pulses, value_o stays 0, abort_cnt_o=1, done_o never asserts.
- Start data=7 delay=0 with abort_i asserted on the expiry edge -> abort wins, value_o unchanged, aborted_o=1.
- Start data=3 delay=5, then start data=9 delay=0 two cycles later -> with DWE_RETRIGGER_EN, value_o=9 one cycle after the retrigger. Without it, value_o=3 at accept+6.
- Assert rst_n low during WAIT (delay=10), release, wait 12 cycles -> value_o=0, no done_o or aborted_o pulse.
- 260 start/abort pairs -> abort_cnt_o saturates at 255. abort_i held high in IDLE -> no pulses and the counter does not change.
